// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD up/down counter with synchronous load, manual
// advance (ADJ), one-cycle carry/borrow pulse and combinational terminal count.
module bcd_mod_counter #(
  parameter int MOD       = 60,
  parameter bit ADJ_CARRY = 1'b0
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [7:0] LOAD_VAL,
  input  logic       ADJ,
  output logic [7:0] Cnt,
  output logic       CO,
  output logic       TC,
  output logic       ERR
);
  localparam int         LAST     = MOD - 1;
  localparam logic [7:0] LAST_BCD = {4'(LAST / 10), 4'(LAST % 10)};

  logic       at_last, at_zero, load_ok;
  logic [7:0] up_nxt, dn_nxt;

  always_comb begin
    at_last = (Cnt == LAST_BCD);
    at_zero = (Cnt == 8'h00);

    if (at_last)              up_nxt = 8'h00;
    else if (Cnt[3:0] == 4'd9) up_nxt = {Cnt[7:4] + 4'd1, 4'd0};
    else                      up_nxt = {Cnt[7:4], Cnt[3:0] + 4'd1};

    if (at_zero)              dn_nxt = LAST_BCD;
    else if (Cnt[3:0] == 4'd0) dn_nxt = {Cnt[7:4] - 4'd1, 4'd9};
    else                      dn_nxt = {Cnt[7:4], Cnt[3:0] - 4'd1};

    // Both digits must be decimal before the weighted value is meaningful.
    load_ok = (LOAD_VAL[7:4] <= 4'd9) && (LOAD_VAL[3:0] <= 4'd9) &&
              ((int'(LOAD_VAL[7:4]) * 10 + int'(LOAD_VAL[3:0])) < MOD);
  end

  // Independent of EN so a following stage can be enabled by EN & TC.
  assign TC = UP ? at_last : at_zero;

  always_ff @(posedge CP) begin
    if (reset) begin
      Cnt <= 8'h00;
      CO  <= 1'b0;
      ERR <= 1'b0;
    end else if (LOAD) begin
      CO <= 1'b0;
      if (load_ok) begin
        Cnt <= LOAD_VAL;
        ERR <= 1'b0;
      end else begin
        ERR <= 1'b1;
      end
    end else if (ADJ) begin
      Cnt <= up_nxt;
      CO  <= ADJ_CARRY && at_last;
    end else if (EN) begin
      Cnt <= UP ? up_nxt : dn_nxt;
      CO  <= UP ? at_last : at_zero;
    end else begin
      CO <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: vector table on a MOD=60 instance, then
// hand sequences for ADJ carry, reset mid-count, full wraps and a 60x60 cascade.
module tb_bcd_mod_counter;
  logic       CP = 1'b0;
  logic       rst, en, up, ld, adj;
  logic [7:0] lv;
  logic [7:0] a_cnt, b_cnt, d_cnt;
  logic       a_co, a_tc, a_err, b_co, b_tc, b_err, d_co, d_tc, d_err;

  logic       c_rst, c_en;
  logic [7:0] s_cnt, m_cnt;
  logic       s_co, s_tc, s_err, m_co, m_tc, m_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CP = ~CP;

  bcd_mod_counter #(.MOD(60), .ADJ_CARRY(1'b0)) u60 (
    .CP(CP), .reset(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv), .ADJ(adj),
    .Cnt(a_cnt), .CO(a_co), .TC(a_tc), .ERR(a_err));
  bcd_mod_counter #(.MOD(60), .ADJ_CARRY(1'b1)) u60c (
    .CP(CP), .reset(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv), .ADJ(adj),
    .Cnt(b_cnt), .CO(b_co), .TC(b_tc), .ERR(b_err));
  bcd_mod_counter #(.MOD(24), .ADJ_CARRY(1'b0)) u24 (
    .CP(CP), .reset(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv), .ADJ(adj),
    .Cnt(d_cnt), .CO(d_co), .TC(d_tc), .ERR(d_err));

  bcd_mod_counter #(.MOD(60)) u_sec (
    .CP(CP), .reset(c_rst), .EN(c_en), .UP(1'b1), .LOAD(1'b0), .LOAD_VAL(8'h00), .ADJ(1'b0),
    .Cnt(s_cnt), .CO(s_co), .TC(s_tc), .ERR(s_err));
  bcd_mod_counter #(.MOD(60)) u_min (
    .CP(CP), .reset(c_rst), .EN(c_en & s_tc), .UP(1'b1), .LOAD(1'b0), .LOAD_VAL(8'h00), .ADJ(1'b0),
    .Cnt(m_cnt), .CO(m_co), .TC(m_tc), .ERR(m_err));

  typedef struct {
    logic rst, en, up, ld;
    logic [7:0] lv;
    logic adj;
    logic [7:0] cnt;
    logic co, err, tc;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [7:0] bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic add(input logic r, e, u, l, input logic [7:0] v, input logic a,
                     input logic [7:0] c, input logic co, er, tc);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v; x.adj = a;
    x.cnt = c; x.co = co; x.err = er; x.tc = tc;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, u, l, input logic [7:0] v, input logic a);
    rst = r; en = e; up = u; ld = l; lv = v; adj = a;
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  int co_seen;

  initial begin
    drive(1, 0, 0, 0, 8'h00, 0);
    c_rst = 1'b1; c_en = 1'b0;

    //   rst en up ld lv     adj  cnt    co er tc
    add(1, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1);
    add(0, 0, 0, 1, 8'h45, 0,  8'h45, 0, 0, 0);
    add(0, 0, 0, 1, 8'h60, 0,  8'h45, 0, 1, 0);
    add(0, 0, 0, 1, 8'h3A, 0,  8'h45, 0, 1, 0);
    add(0, 0, 0, 1, 8'h12, 0,  8'h12, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0,  8'h13, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0,  8'h12, 0, 0, 0);
    add(0, 0, 0, 1, 8'h09, 0,  8'h09, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0,  8'h10, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0,  8'h09, 0, 0, 0);
    add(0, 0, 1, 1, 8'h59, 0,  8'h59, 0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 1,  8'h00, 0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 0,  8'h59, 1, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0,  8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0,  8'h00, 0, 0, 1);
    add(0, 0, 0, 1, 8'h30, 0,  8'h30, 0, 0, 0);
    add(0, 1, 1, 1, 8'h07, 1,  8'h07, 0, 0, 0);
    add(0, 0, 0, 1, 8'h60, 0,  8'h07, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 0,  8'h08, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1,  8'h09, 0, 1, 0);
    add(1, 1, 0, 1, 8'h12, 1,  8'h00, 0, 0, 1);
    add(0, 0, 0, 1, 8'h99, 0,  8'h00, 0, 1, 1);
    add(0, 1, 1, 0, 8'h00, 0,  8'h01, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv, vecs[i].adj);
      step();
      chk($sformatf("vec%0d cnt", i), a_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d co", i),  a_co,  vecs[i].co);
      chk($sformatf("vec%0d err", i), a_err, vecs[i].err);
      chk($sformatf("vec%0d tc", i),  a_tc,  vecs[i].tc);
    end

    // ADJ wrap: carry only on the ADJ_CARRY=1 instance
    drive(0, 0, 0, 1, 8'h59, 0); step();
    drive(0, 0, 0, 0, 8'h00, 1); step();
    chk("adjc cnt", b_cnt, 8'h00);
    chk("adjc co", b_co, 1'b1);
    chk("adj0 cnt", a_cnt, 8'h00);
    chk("adj0 co", a_co, 1'b0);
    drive(0, 0, 0, 0, 8'h00, 0); step();
    chk("adjc co drop", b_co, 1'b0);

    // Reset mid-count discards the step, resumes from 00
    drive(1, 0, 0, 0, 8'h00, 0); step();
    drive(0, 1, 1, 0, 8'h00, 0); step(); step(); step();
    chk("pre-rst cnt", a_cnt, 8'h03);
    drive(1, 1, 1, 0, 8'h00, 0); step();
    chk("mid-rst cnt", a_cnt, 8'h00);
    drive(0, 1, 1, 0, 8'h00, 0); step();
    chk("post-rst cnt", a_cnt, 8'h01);

    // Full modulo-60 up sequence from 00
    drive(1, 0, 0, 0, 8'h00, 0); step();
    drive(0, 1, 1, 0, 8'h00, 0);
    co_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk($sformatf("up60 cnt%0d", i), a_cnt, bcd((i + 1) % 60));
      chk($sformatf("up60 co%0d", i), a_co, (i == 59));
      if (a_co) co_seen++;
    end
    chk("up60 co count", 16'(co_seen), 16'd1);

    // Modulo-24 down from 00: borrow to 23, then across tens
    drive(1, 0, 0, 0, 8'h00, 0); step();
    drive(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("dn24 cnt%0d", i), d_cnt, bcd(23 - i));
      chk($sformatf("dn24 co%0d", i), d_co, (i == 0));
    end

    // Cascade seconds -> minutes
    drive(0, 0, 0, 0, 8'h00, 0);
    c_rst = 1'b1; step();
    c_rst = 1'b0; c_en = 1'b1;
    co_seen = 0;
    for (int i = 0; i < 3599; i++) begin
      step();
      if (m_co) co_seen++;
    end
    chk("casc sec 59", s_cnt, 8'h59);
    chk("casc min 59", m_cnt, 8'h59);
    step();
    if (m_co) co_seen++;
    chk("casc sec 00", s_cnt, 8'h00);
    chk("casc min 00", m_cnt, 8'h00);
    chk("casc min co", m_co, 1'b1);
    chk("casc min co count", 16'(co_seen), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
